// File: rtl/axil_regbank_pkg.sv
// axil_regbank_pkg: response codes and address decode shared by the register bank.
// The ISR/IER slots exist only when AXIL_REGBANK_IRQ_EN is defined.
package axil_regbank_pkg;
  typedef enum logic [1:0] {RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10} resp_t;
  typedef enum logic [2:0] {DEC_RW, DEC_RO, DEC_ISR, DEC_IER, DEC_ERR} decode_t;
  function automatic decode_t decode(input logic [31:0] idx, input int num_rw, input int num_ro);
    if (idx < 32'(num_rw)) return DEC_RW;
    if (idx < 32'(num_rw + num_ro)) return DEC_RO;
`ifdef AXIL_REGBANK_IRQ_EN
    if (idx == 32'(num_rw + num_ro)) return DEC_ISR;
    if (idx == 32'(num_rw + num_ro + 1)) return DEC_IER;
`endif
    return DEC_ERR;
  endfunction
endpackage

// File: rtl/axil_wr_hold.sv
// axil_wr_hold: one-entry holding register for an AXI channel; the incoming beat bypasses
// the entry when the consumer takes it in the same cycle.
module axil_wr_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         ready,
  input  logic         take,
  output logic         avail,
  output logic [W-1:0] data
);
  logic         full;
  logic [W-1:0] q;
  assign ready = !full;
  assign avail = full || in_valid;
  assign data  = full ? q : in_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      full <= 1'b0;
      q    <= '0;
    end else if (take) full <= 1'b0;
    else if (in_valid && !full) begin
      full <= 1'b1;
      q    <= in_data;
    end
endmodule

// File: rtl/axil_regbank.sv
// axil_regbank: AXI4-Lite slave with NUM_RW control and NUM_RO status registers.
// Define AXIL_REGBANK_IRQ_EN to add the ISR (W1C) and IER registers and drive irq_o.
module axil_regbank
  import axil_regbank_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 8,
  parameter int                NUM_RW  = 12,
  parameter int                NUM_RO  = 4,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [DATA_W-1:0]        S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]      S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [DATA_W-1:0]        S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [NUM_RW*DATA_W-1:0] ctrl_o,
  output logic [NUM_RW-1:0]        wr_pulse_o,
  input  logic [NUM_RO*DATA_W-1:0] status_i,
  input  logic [DATA_W-1:0]        irq_src_i,
  output logic                     irq_o
);
  localparam int BYTES = DATA_W / 8;
  localparam int LSB = $clog2(BYTES);
  logic              aw_avail, w_avail, commit, bvalid, rvalid;
  logic [ADDR_W-1:0] aw_addr;
  logic [DATA_W-1:0] w_data, mask, rd, rdata;
  logic [BYTES-1:0]  w_strb;
  logic [31:0]       w_idx, r_idx;
  decode_t           w_dec, r_dec;
  resp_t             bresp, rresp;
  logic [DATA_W-1:0] regs [NUM_RW];
  axil_wr_hold #(.W(ADDR_W)) u_aw (
    .clk(ACLK), .rst(ARESET), .in_valid(S_AXI_AWVALID), .in_data(S_AXI_AWADDR),
    .ready(S_AXI_AWREADY), .take(commit), .avail(aw_avail), .data(aw_addr)
  );
  axil_wr_hold #(.W(DATA_W + BYTES)) u_w (
    .clk(ACLK), .rst(ARESET), .in_valid(S_AXI_WVALID), .in_data({S_AXI_WSTRB, S_AXI_WDATA}),
    .ready(S_AXI_WREADY), .take(commit), .avail(w_avail), .data({w_strb, w_data})
  );
  // a new write waits until the previous response has been accepted
  assign commit = aw_avail && w_avail && !bvalid;
  assign w_idx  = 32'(aw_addr >> LSB);
  assign r_idx  = 32'(S_AXI_ARADDR >> LSB);
  assign w_dec  = decode(w_idx, NUM_RW, NUM_RO);
  assign r_dec  = decode(r_idx, NUM_RW, NUM_RO);
  genvar b, k;
  for (b = 0; b < BYTES; b++) begin : g_mask
    assign mask[b*8 +: 8] = {8{w_strb[b]}};
  end
  for (k = 0; k < NUM_RW; k++) begin : g_ctrl
    assign ctrl_o[k*DATA_W +: DATA_W] = regs[k];
  end
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      for (int i = 0; i < NUM_RW; i++) regs[i] <= RST_VAL;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      for (int i = 0; i < NUM_RW; i++)
        if (commit && w_dec == DEC_RW && w_idx == 32'(i)) begin
          regs[i]       <= (regs[i] & ~mask) | (w_data & mask);
          wr_pulse_o[i] <= 1'b1;
        end
    end
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      bvalid <= 1'b0;
      bresp  <= RESP_OKAY;
    end else if (commit) begin
      bvalid <= 1'b1;
      bresp  <= w_dec == DEC_ERR ? RESP_SLVERR : RESP_OKAY;
    end else if (S_AXI_BREADY) bvalid <= 1'b0;
`ifdef AXIL_REGBANK_IRQ_EN
  logic [DATA_W-1:0] isr, ier;
  // sources are OR-ed in after the clear so a simultaneous set wins
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      isr   <= '0;
      ier   <= '0;
      irq_o <= 1'b0;
    end else begin
      isr   <= (isr & ~((commit && w_dec == DEC_ISR) ? (w_data & mask) : '0)) | irq_src_i;
      ier   <= (commit && w_dec == DEC_IER) ? ((ier & ~mask) | (w_data & mask)) : ier;
      irq_o <= |(isr & ier);
    end
`else
  assign irq_o = 1'b0 & ^irq_src_i;
`endif
  always_comb begin
    rd = '0;
    for (int i = 0; i < NUM_RW; i++) rd = (r_idx == 32'(i)) ? regs[i] : rd;
    for (int j = 0; j < NUM_RO; j++) rd = (r_idx == 32'(NUM_RW + j)) ? status_i[j*DATA_W +: DATA_W] : rd;
`ifdef AXIL_REGBANK_IRQ_EN
    rd = r_dec == DEC_ISR ? isr : r_dec == DEC_IER ? ier : rd;
`endif
  end
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (S_AXI_ARVALID && !rvalid) begin
      rvalid <= 1'b1;
      rdata  <= rd;
      rresp  <= r_dec == DEC_ERR ? RESP_SLVERR : RESP_OKAY;
    end else if (S_AXI_RREADY) rvalid <= 1'b0;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_ARREADY = !rvalid;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = rresp;
endmodule

// File: tb/tb_axil_regbank.sv
// tb_axil_regbank: randomized AXI-Lite traffic against a register-map model with a B/R scoreboard.
module tb_axil_regbank;
  localparam int NRW = 12, NRO = 4;
  localparam logic [31:0] RV = 32'h5A5A_00C3;
`ifdef AXIL_REGBANK_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] awaddr = '0, araddr = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid, irq;
  logic [31:0] wdata = '0, rdata, irq_src = '0;
  logic [3:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  logic [NRW*32-1:0] ctrl;
  logic [NRW-1:0] pulse;
  logic [NRO*32-1:0] status = '0;
  logic hold_b = 0, hold_r = 0;
  logic [31:0] mreg [NRW];
  logic [31:0] mst [NRO];
  logic [31:0] misr = '0, mier = '0;
  logic [1:0] bq [$];
  logic [33:0] rq [$];
  int n_cmp = 0, n_bad = 0;

  axil_regbank #(.DATA_W(32), .ADDR_W(8), .NUM_RW(NRW), .NUM_RO(NRO), .RST_VAL(RV)) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ctrl_o(ctrl), .wr_pulse_o(pulse), .status_i(status), .irq_src_i(irq_src), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) old[i*8 +: 8] = d[i*8 +: 8];
    return old;
  endfunction

  task automatic expect_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a >> 2);
    if (idx < NRW) mreg[idx] = merge(mreg[idx], d, s);
    else if (IRQ && idx == NRW + NRO) misr = misr & ~merge(32'h0, d, s);
    else if (IRQ && idx == NRW + NRO + 1) mier = merge(mier, d, s);
    bq.push_back((idx < NRW + NRO || (IRQ && idx < NRW + NRO + 2)) ? 2'b00 : 2'b10);
  endtask

  task automatic expect_read(input logic [7:0] a);
    int idx = int'(a >> 2);
    logic [31:0] d = '0;
    logic [1:0] r = 2'b00;
    if (idx < NRW) d = mreg[idx];
    else if (idx < NRW + NRO) d = mst[idx - NRW];
    else if (IRQ && idx == NRW + NRO) d = misr;
    else if (IRQ && idx == NRW + NRO + 1) d = mier;
    else r = 2'b10;
    rq.push_back({r, d});
  endtask

  // scoreboard monitor: pops an expectation whenever a B or R handshake is about to happen
  always @(negedge clk) begin
    logic [1:0] eb;
    logic [33:0] er;
    if (!rst && bvalid && bready) begin
      if (bq.size() == 0) chk("b_unexpected", 1, 0);
      else begin
        eb = bq.pop_front();
        chk("bresp", bresp, eb);
      end
    end
    if (!rst && rvalid && rready) begin
      if (rq.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        er = rq.pop_front();
        chk("rdata", rdata, er[31:0]);
        chk("rresp", rresp, er[33:32]);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    bready = hold_b ? 1'b0 : ($urandom_range(0, 3) != 0);
    rready = hold_r ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic put_aw(input logic [7:0] a);
    int t = 0;
    awaddr = a;
    awvalid = 1;
    @(negedge clk);
    while (!awready && t < 200) begin @(negedge clk); t++; end
    chk("aw_handshake", awready, 1);
    @(posedge clk); #1;
    awvalid = 0;
  endtask

  task automatic put_w(input logic [31:0] d, input logic [3:0] s);
    int t = 0;
    wdata = d;
    wstrb = s;
    wvalid = 1;
    @(negedge clk);
    while (!wready && t < 200) begin @(negedge clk); t++; end
    chk("w_handshake", wready, 1);
    @(posedge clk); #1;
    wvalid = 0;
  endtask

  task automatic issue_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input int da, input int dw);
    expect_write(a, d, s);
    fork
      begin if (da > 0) begin repeat (da) @(posedge clk); #1; end put_aw(a); end
      begin if (dw > 0) begin repeat (dw) @(posedge clk); #1; end put_w(d, s); end
    join
  endtask

  task automatic issue_read(input logic [7:0] a);
    int t = 0;
    expect_read(a);
    araddr = a;
    arvalid = 1;
    @(negedge clk);
    while (!arready && t < 200) begin @(negedge clk); t++; end
    chk("ar_handshake", arready, 1);
    @(posedge clk); #1;
    arvalid = 0;
  endtask

  task automatic wait_b();
    int t = 0;
    while (bq.size() != 0 && t < 300) begin @(negedge clk); t++; end
    chk("b_drain", bq.size(), 0);
    bq.delete();
    @(posedge clk); #1;
  endtask

  task automatic wait_r();
    int t = 0;
    while (rq.size() != 0 && t < 300) begin @(negedge clk); t++; end
    chk("r_drain", rq.size(), 0);
    rq.delete();
    @(posedge clk); #1;
  endtask

  task automatic chk_ctrl();
    for (int i = 0; i < NRW; i++) chk($sformatf("ctrl%0d", i), ctrl[i*32 +: 32], mreg[i]);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0] a;
    for (int i = 0; i < NRW; i++) mreg[i] = RV;
    for (int j = 0; j < NRO; j++) begin
      mst[j] = (j == 0) ? 32'hDEAD_BEEF : $urandom;
      status[j*32 +: 32] = mst[j];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_resps", {bresp, rresp}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_pulse", pulse, 0);
    chk("rst_irq", irq, 0);
    chk_ctrl();
    rst = 0;
    @(posedge clk); #1;

    // same-cycle AW+W: response and pulse one cycle later
    hold_b = 1; bready = 0;
    issue_write(8'h04, 32'hA5A5_0001, 4'hF, 0, 0);
    @(negedge clk);
    chk("t1_bvalid", bvalid, 1);
    chk("t1_bresp", bresp, 0);
    chk("t1_pulse", pulse, 12'h002);
    @(negedge clk);
    chk("t1_pulse_end", pulse, 0);
    hold_b = 0;
    wait_b();
    chk("t1_reg1", ctrl[32 +: 32], 32'hA5A5_0001);
    issue_read(8'h04);
    wait_r();

    // W leads AW; partial strobe merge
    expect_write(8'h08, 32'h1122_3344, 4'hF);
    put_w(32'h1122_3344, 4'hF);
    @(negedge clk);
    chk("t2_wready_held", wready, 0);
    chk("t2_no_commit", bvalid, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    put_aw(8'h08);
    wait_b();
    issue_write(8'h08, 32'hFFFF_FFFF, 4'b0010, 0, 0);
    wait_b();
    chk("t2_reg2", ctrl[64 +: 32], 32'h1122_FF44);
    issue_read(8'h08);
    wait_r();

    // second write captured while B stalls, commits after the handshake
    hold_b = 1; bready = 0;
    issue_write(8'hFC, 32'h1234_5678, 4'hF, 0, 0);
    repeat (5) begin
      @(negedge clk);
      chk("t3_bvalid", bvalid, 1);
      chk("t3_bresp", bresp, 2'b10);
    end
    @(posedge clk); #1;
    issue_write(8'h14, 32'hCAFE_F00D, 4'hF, 1, 0);
    @(negedge clk);
    chk("t3_aw_full", awready, 0);
    chk("t3_w_full", wready, 0);
    chk("t3_bresp_stable", bresp, 2'b10);
    chk("t3_reg5_old", ctrl[5*32 +: 32], RV);
    hold_b = 0;
    wait_b();
    chk("t3_reg5_new", ctrl[5*32 +: 32], 32'hCAFE_F00D);

    // status register, write-ignored status, out of range
    issue_read(8'h30);
    wait_r();
    issue_write(8'h30, 32'h0, 4'hF, 0, 2);
    wait_b();
    chk_ctrl();
    issue_read(8'h31);
    wait_r();
    issue_read(8'hFF);
    wait_r();

    // R stall, then reset in the middle of a write
    hold_r = 1; rready = 0;
    issue_read(8'h08);
    repeat (4) begin
      @(negedge clk);
      chk("t5_rvalid", rvalid, 1);
      chk("t5_arready", arready, 0);
      chk("t5_rdata", rdata, 32'h1122_FF44);
    end
    hold_r = 0;
    wait_r();
    @(negedge clk);
    chk("t5_arready_back", arready, 1);
    @(posedge clk); #1;
    hold_b = 1; bready = 0;
    issue_write(8'h1C, 32'h0BAD_0BAD, 4'hF, 0, 0);
    put_aw(8'h20);
    chk("t5_bvalid_pend", bvalid, 1);
    rst = 1;
    #1;
    chk("t5_rst_bvalid", bvalid, 0);
    chk("t5_rst_awready", awready, 1);
    chk("t5_rst_wready", wready, 1);
    chk("t5_rst_pulse", pulse, 0);
    bq.delete();
    for (int i = 0; i < NRW; i++) mreg[i] = RV;
    misr = '0;
    mier = '0;
    chk_ctrl();
    @(posedge clk); #1;
    rst = 0;
    hold_b = 0;
    issue_write(8'h24, 32'h600D_F00D, 4'hF, 2, 0);
    wait_b();
    chk_ctrl();

`ifdef AXIL_REGBANK_IRQ_EN
    issue_write(8'h44, 32'h1, 4'hF, 0, 0);
    wait_b();
    irq_src = 32'h1;
    @(posedge clk); #1;
    irq_src = 32'h0;
    misr = 32'h1;
    @(negedge clk);
    chk("t6_irq_early", irq, 0);
    @(negedge clk);
    chk("t6_irq_set", irq, 1);
    @(posedge clk); #1;
    issue_read(8'h40);
    wait_r();
    issue_write(8'h40, 32'h1, 4'hF, 0, 0);
    wait_b();
    @(negedge clk);
    chk("t6_irq_cleared", irq, 0);
    @(posedge clk); #1;
    irq_src = 32'h1;
    issue_write(8'h40, 32'h1, 4'hF, 0, 0);
    misr = 32'h1;
    wait_b();
    irq_src = 32'h0;
    issue_read(8'h40);
    wait_r();
    chk("t6_irq_kept", irq, 1);
    issue_write(8'h40, 32'hFFFF_FFFF, 4'hF, 0, 0);
    wait_b();
    issue_write(8'h44, 32'h0, 4'hF, 0, 0);
    wait_b();
`else
    issue_read(8'h40);
    wait_r();
    issue_write(8'h44, 32'h1, 4'hF, 0, 0);
    wait_b();
    irq_src = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_irq_off", irq, 0);
    irq_src = 32'h0;
`endif

    // randomized traffic against the register-map model
    repeat (200) begin
      a = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 79)) : 8'($urandom);
      d = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        issue_write(a, d, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        wait_b();
        chk_ctrl();
      end else begin
        issue_read(a);
        wait_r();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
